// File: rtl/ex_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit_if
//   Groups the EX-stage handshake between the pipeline and the iterative
//   RV32M multiply/divide unit.
//
//   master : pipeline side. Drives the request (flush, start, op, operands,
//            rd_in) and receives stall/done/result/rd_out.
//   slave  : the muldiv unit.
//
//   flush   pipeline redirect; kills any in-flight op
//   start   EX holds a valid M-extension op this cycle
//   op      funct3 of the M op
//   src_a   rs1 operand (post-forwarding)
//   src_b   rs2 operand (post-forwarding)
//   rd_in   destination register of the op
//   stall   freeze front of pipeline while the unit is busy
//   done    one-cycle pulse; result/rd_out valid
//   result  op result
//   rd_out  destination register of the completed op
// ----------------------------------------------------------------------------
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [4:0]      rd_in;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output flush, start, op, src_a, src_b, rd_in,
    input  stall, done, result, rd_out
  );

  modport slave (
    input  flush, start, op, src_a, src_b, rd_in,
    output stall, done, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit for the EX stage. Executes MUL,
//   MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU one bit per cycle on operand
//   magnitudes, then applies the result sign on the final iteration.
//
//   Sequencing: IDLE -> CALC (XLEN cycles) -> DONE -> IDLE.
//   Divide-by-zero and signed overflow bypass CALC and complete one cycle
//   after acceptance.
//
// Ports
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-low reset
//   bus   ex_muldiv_unit_if.slave (request in, stall/done/result/rd_out out)
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  ex_muldiv_unit_if.slave       bus
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_q;     // negate the final selected result
  logic [XLEN-1:0] opnd_q;    // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0] acc_hi;    // product high half / partial remainder
  logic [XLEN-1:0] acc_lo;    // multiplier bits / dividend-quotient shift
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  // --------------------------------------------------------------------------
  // Acceptance decode (only meaningful in IDLE with start high)
  // --------------------------------------------------------------------------
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            neg_in;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
    is_div      = bus.op[2];
    a_signed    = (bus.op == OP_MUL) || (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                  (bus.op == OP_DIV) || (bus.op == OP_REM);
    b_signed    = (bus.op == OP_MUL) || (bus.op == OP_MULH) ||
                  (bus.op == OP_DIV) || (bus.op == OP_REM);
    sign_a      = a_signed & bus.src_a[XLEN-1];
    sign_b      = b_signed & bus.src_b[XLEN-1];
    mag_a       = sign_a ? -bus.src_a : bus.src_a;
    mag_b       = sign_b ? -bus.src_b : bus.src_b;
    // Remainder takes the dividend's sign; quotient and product take sa^sb.
    neg_in      = (is_div && bus.op[1]) ? sign_a : (sign_a ^ sign_b);
    div_zero    = is_div && (bus.src_b == '0);
    div_ovf     = is_div && !bus.op[0] && (bus.src_a == MOST_NEG) && (bus.src_b == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = bus.op[1] ? bus.src_a : '1;
    end else if (div_ovf) begin
      special_res = bus.op[1] ? '0 : MOST_NEG;
    end
  end

  // --------------------------------------------------------------------------
  // One iteration of shift-add multiply or restoring divide
  // --------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   nxt_hi;
  logic [XLEN-1:0]   nxt_lo;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   div_raw;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    // Multiply: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole {carry, hi, lo} right.
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
    // Divide: shift the next dividend bit into the partial remainder and
    // subtract the divisor; the borrow bit tells whether it fit.
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[XLEN];

    if (op_q[2]) begin
      nxt_hi = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      nxt_lo = {acc_lo[XLEN-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end

    prod    = {nxt_hi, nxt_lo};
    prod_s  = neg_q ? -prod : prod;
    div_raw = op_q[1] ? nxt_hi : nxt_lo;

    if (op_q[2]) begin
      final_res = neg_q ? -div_raw : div_raw;
    end else if (op_q[1:0] == 2'b00) begin
      final_res = prod_s[XLEN-1:0];
    end else begin
      final_res = prod_s[2*XLEN-1:XLEN];
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      // NOTE: the datapath registers are few and cheap, so they are reset with the control state.
      state    <= IDLE;
      count    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (bus.flush) begin
      // Redirect wins over everything, including a start in the same cycle.
      state  <= IDLE;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q   <= bus.op;
            rd_q   <= bus.rd_in;
            neg_q  <= neg_in;
            count  <= CW'(XLEN);
            acc_hi <= '0;
            if (is_div) begin
              opnd_q <= mag_b;
              acc_lo <= mag_a;
            end else begin
              opnd_q <= mag_a;
              acc_lo <= mag_b;
            end
            if (special) begin
              result_q <= special_res;
              rd_out_q <= bus.rd_in;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          count  <= count - 1'b1;
          if (count == CW'(1)) begin
            result_q <= final_res;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          // Any start seen here is re-presented by ID/EX in the next IDLE.
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Stall drops in DONE so the pipeline advances and EX/MEM captures result.
  assign bus.stall  = ((state == IDLE) && bus.start) || (state == CALC);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule
